fetch_stage: RTL and testbench

- IF stage of the 5-stage RV32I core.
- Holds the program counter and drives the instruction memory address (word-indexed by A[31:2], combinational read).
- Captures the returned word, with its PC and PC+4, into the IF/ID pipeline register.
- Hazard unit controls it through stall, flush and E-stage branch/jump redirect.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage_if_id_reg.sv | 32 +++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the RV32I instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            misalign;
    } if_id_t;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Hazard-control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;

    logic        stall_f;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign_d;

    modport master (
        input  stall_f, flush_d, pc_src_e, pc_target_e, imem_rdata_i,
        output imem_addr_o, instr_d, pc_d, pc_plus4_d, valid_d, misalign_d
    );

    modport slave (
        output stall_f, flush_d, pc_src_e, pc_target_e, imem_rdata_i,
        input  imem_addr_o, instr_d, pc_d, pc_plus4_d, valid_d, misalign_d
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, stall holds, else load.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   stall,
    input  if_id_t d,
    output if_id_t q
);

    // A bubble keeps pc/pc_plus4 so the bubble still carries its last PC context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.instr    <= NOP_INSTR;
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.valid    <= 1'b0;
            q.misalign <= 1'b0;
        end else if (flush) begin
            q.instr    <= NOP_INSTR;
            q.valid    <= 1'b0;
            q.misalign <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC, next-PC select, boot FSM and IF/ID capture.
// Optional misaligned-redirect flag enabled by `define FETCH_MISALIGN_TRAP_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);

    fetch_state_e    state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic            ifid_flush_c;
    logic            misalign_c;
    if_id_t          ifid_d, ifid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
        end
    end

    // BOOT discards the memory word seen on the reset-release cycle.
    always_comb begin
        state_n      = state_q;
        pc_n         = pc_q;
        ifid_flush_c = 1'b0;
        case (state_q)
            BOOT: begin
                state_n      = RUN;
                ifid_flush_c = 1'b1;
            end
            RUN: begin
                ifid_flush_c = bus.flush_d;
                if (bus.pc_src_e) begin
                    pc_n = {bus.pc_target_e[XLEN-1:2], 2'b00};
                end else if (!bus.stall_f) begin
                    pc_n = pc_inc(pc_q);
                end
            end
            default: begin
                state_n      = BOOT;
                ifid_flush_c = 1'b1;
            end
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic pend_q, pend_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_n;
        end
    end

    // A redirect's own flush must not clear the flag it is setting.
    always_comb begin
        pend_n = pend_q;
        if (state_q == RUN) begin
            if (bus.pc_src_e) begin
                pend_n = |bus.pc_target_e[1:0];
            end else if (bus.flush_d || !bus.stall_f) begin
                pend_n = 1'b0;
            end
        end
    end

    assign misalign_c = pend_q;
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^bus.pc_target_e[1:0];
    assign misalign_c     = 1'b0;
`endif

    always_comb begin
        ifid_d.instr    = bus.imem_rdata_i;
        ifid_d.pc       = pc_q;
        ifid_d.pc_plus4 = pc_inc(pc_q);
        ifid_d.valid    = 1'b1;
        ifid_d.misalign = misalign_c;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .flush (ifid_flush_c),
        .stall (bus.stall_f),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign bus.imem_addr_o = pc_q;
    assign bus.instr_d     = ifid_q.instr;
    assign bus.pc_d        = ifid_q.pc;
    assign bus.pc_plus4_d  = ifid_q.pc_plus4;
    assign bus.valid_d     = ifid_q.valid;
    assign bus.misalign_d  = ifid_q.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table with expected IF/ID state after each edge.
module tb_fetch_stage;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        src;
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } vec_t;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NVEC = 24;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    vec_t vecs [NVEC];
    vec_t sb_q [$];

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Instruction memory: three program words, then an address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h0020_81B3;
            default: return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    always_comb bus.imem_rdata_i = mem_word(bus.imem_addr_o);

    function automatic vec_t mk(input logic s, input logic f, input logic r,
                                input logic [31:0] t, input logic [31:0] ad,
                                input logic [31:0] in, input logic [31:0] p,
                                input logic [31:0] p4, input logic v, input logic m);
        vec_t x;
        x.stall = s; x.flush = f; x.src = r; x.tgt = t;
        x.addr = ad; x.instr = in; x.pc = p; x.pc4 = p4; x.valid = v; x.mis = m;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, " imem_addr"}, bus.imem_addr_o, e.addr);
        check({tag, " instr_d"}, bus.instr_d, e.instr);
        check({tag, " pc_d"}, bus.pc_d, e.pc);
        check({tag, " pc_plus4_d"}, bus.pc_plus4_d, e.pc4);
        check({tag, " valid_d"}, 32'(bus.valid_d), 32'(e.valid));
        check({tag, " misalign_d"}, 32'(bus.misalign_d), 32'(e.mis));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        bus.stall_f     = v.stall;
        bus.flush_d     = v.flush;
        bus.pc_src_e    = v.src;
        bus.pc_target_e = v.tgt;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s scoreboard: got empty queue, expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            check_outputs(tag, e);
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t rv;
        tests = 0;
        fails = 0;
        //            stall flush src  tgt            addr           instr          pc             pc4            v     mis
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        NOP,          32'h0,        32'h0,        1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h002081B3, 32'h8,        32'hC,        1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'hC0DE000C, 32'hC,        32'h10,       1'b1, 1'b0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 32'h40,       32'h40,       NOP,          32'hC,        32'h10,       1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'hC0DE0040, 32'h40,       32'h44,       1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,        32'h44,       NOP,          32'h40,       32'h44,       1'b0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h80,       32'h80,       32'hC0DE0044, 32'h44,       32'h48,       1'b1, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h84,       32'hC0DE0080, 32'h80,       32'h84,       1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,          32'h80,       32'h84,       1'b0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h3F21FFFC, 32'hFFFFFFFC, 32'h0,        1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b1, 32'h42,       32'h40,       NOP,          32'h0,        32'h4,        1'b0, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'hC0DE0040, 32'h40,       32'h44,       1'b1, EXP_MIS);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h48,       32'hC0DE0044, 32'h44,       32'h48,       1'b1, 1'b0);
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 32'h43,       32'h40,       NOP,          32'h44,       32'h48,       1'b0, 1'b0);
        vecs[20] = mk(1'b0, 1'b1, 1'b0, 32'h0,        32'h44,       NOP,          32'h44,       32'h48,       1'b0, 1'b0);
        vecs[21] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h48,       32'hC0DE0044, 32'h44,       32'h48,       1'b1, 1'b0);
        vecs[22] = mk(1'b0, 1'b1, 1'b1, 32'h1C,       32'h1C,       NOP,          32'h44,       32'h48,       1'b0, 1'b0);
        vecs[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,        32'h20,       32'hC0DE001C, 32'h1C,       32'h20,       1'b1, 1'b0);

        rst             = 1'b1;
        bus.stall_f     = 1'b0;
        bus.flush_d     = 1'b0;
        bus.pc_src_e    = 1'b0;
        bus.pc_target_e = 32'h0;

        @(negedge clk);
        rv = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        check_outputs("reset", rv);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-stream at pc_f=0x20, checked before any clock edge.
        rst = 1'b1;
        #1;
        check_outputs("async_reset", rv);
        @(negedge clk);
        rst = 1'b0;
        step("post_reset_boot", mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0));
        step("post_reset_fetch", mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 32'h00500093, 32'h0, 32'h4, 1'b1, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
